mem_arbiter: RTL and testbench

- Shares one single-port data memory between two requesters: port 0 is the MIPS core data port (the core's memwrite/aluout/writedata/readdata traffic) and port 1 is a DMA/program loader.
- Uses a valid/ready request handshake, round-robin arbitration and one outstanding access at a time.
- Read latency of the memory is configurable.
- Sits between the core/loader and the memory macro. The core stalls while its ready is low.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/rr_pick2.sv | 30 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  localparam int unsigned REQ_CPU    = 0;
  localparam int unsigned REQ_DMA    = 1;
  localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker: round-robin on prio, or fixed cpu-first when
// MEM_ARB_CPU_PRIORITY_EN is defined.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Pick one requester; grant is the one-hot form of grant_idx when any is valid.
  always_comb begin
    grant     = '0;
    grant_idx = 1'b0;
    if (valid[REQ_CPU] && valid[REQ_DMA]) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      grant_idx = 1'(REQ_CPU);
`else
      grant_idx = prio;
`endif
    end else if (valid[REQ_DMA]) begin
      grant_idx = 1'(REQ_DMA);
    end
    if (valid != '0) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between the MIPS core data port (0) and a
// DMA/program loader (1). One outstanding access; reads wait RD_LAT cycles.
// Optional build macro: MEM_ARB_CPU_PRIORITY_EN (fixed cpu-first priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            grant_id
);

  localparam int unsigned CW = $clog2(RD_LAT_MAX + 1);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT %0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
  end

  arb_state_t    state, state_nx;
  logic          prio, prio_nx;
  logic          grant_id_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pend_id, pend_id_nx;

  logic [1:0]    pick_grant;
  logic          pick_idx;

  rr_pick2 u_pick (
    .valid     (req_valid),
    .prio      (prio),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      prio     <= 1'b0;
      grant_id <= 1'b0;
      cnt      <= '0;
      pend_id  <= 1'b0;
    end else begin
      state    <= state_nx;
      prio     <= prio_nx;
      grant_id <= grant_id_nx;
      cnt      <= cnt_nx;
      pend_id  <= pend_id_nx;
    end
  end

  // Next-state and output decode; everything is held idle while reset is high
  // so a read caught by reset never produces a response.
  always_comb begin
    state_nx    = state;
    prio_nx     = prio;
    grant_id_nx = grant_id;
    cnt_nx      = cnt;
    pend_id_nx  = pend_id;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (!reset) begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_grant != '0) begin
            req_ready   = pick_grant;
            mem_en      = 1'b1;
            mem_we      = req_we[pick_idx];
            mem_addr    = pick_idx ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
            mem_wdata   = pick_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
            grant_id_nx = pick_idx;
`ifdef MEM_ARB_CPU_PRIORITY_EN
            prio_nx     = 1'b0;
`else
            prio_nx     = ~pick_idx;
`endif
            if (!req_we[pick_idx]) begin
              state_nx   = ARB_WAIT;
              cnt_nx     = CW'(1);
              pend_id_nx = pick_idx;
            end
          end
        end
        ARB_WAIT: begin
          if (cnt == CW'(RD_LAT)) begin
            rsp_valid[pend_id] = 1'b1;
            rsp_rdata          = mem_rdata;
            state_nx           = ARB_IDLE;
            cnt_nx             = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: state_nx = ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-deadline reference model.
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned RDL = 3;

  logic            clk;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            grant_id;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RDL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: absolute-cycle bookkeeping of the outstanding read.
  bit m_prio, m_gid, m_rd, m_pend;
  int m_rsp_cyc;
  int m_last_g;

  // Outputs sampled during the most recent cycle.
  logic [1:0]    s_ready, s_rsp;
  logic          s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs, check against the model, then clock.
  task automatic cycle(input logic rst, input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] rdata);
    logic [1:0]    e_ready, e_rsp;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rdata;
    int            g;
    bit            rsp_now;
    reset     = rst;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    mem_rdata = rdata;
    #2;
    e_ready = '0; e_rsp = '0; e_en = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wd = '0; e_rdata = '0;
    g = -1;
    rsp_now = !rst && m_rd && (cyc == m_rsp_cyc);
    if (rsp_now) begin
      e_rsp[m_pend] = 1'b1;
      e_rdata       = rdata;
    end
    if (!rst && !m_rd) begin
      if (v == 2'b11) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
        g = 0;
`else
        g = int'(m_prio);
`endif
      end else if (v[0]) g = 0;
      else if (v[1]) g = 1;
    end
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      e_en       = 1'b1;
      e_we       = we[g];
      e_addr     = (g == 1) ? a1 : a0;
      e_wd       = (g == 1) ? d1 : d0;
    end
    s_ready = req_ready; s_rsp = rsp_valid; s_en = mem_en; s_we = mem_we;
    s_addr = mem_addr; s_rdata = rsp_rdata;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
    chk("mem_en",    64'(mem_en),    64'(e_en));
    chk("mem_we",    64'(mem_we),    64'(e_we));
    chk("mem_addr",  64'(mem_addr),  64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    chk("grant_id",  64'(grant_id),  64'(m_gid));
    m_last_g = g;
    @(posedge clk);
    #1;
    if (rst) begin
      m_prio = 0; m_gid = 0; m_rd = 0; m_pend = 0;
    end else begin
      if (rsp_now) m_rd = 0;
      if (g >= 0) begin
        m_prio = (g == 0);
        m_gid  = (g == 1);
        if (!we[g]) begin
          m_rd      = 1;
          m_pend    = (g == 1);
          m_rsp_cyc = cyc + int'(RDL);
        end
      end
    end
    cyc++;
  endtask

  logic [1:0]    pv, pwe;
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  logic          rr;

  initial begin
    reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0;
    req_wdata = '0; mem_rdata = '0;
    m_prio = 0; m_gid = 0; m_rd = 0; m_pend = 0; m_rsp_cyc = 0; m_last_g = -1;
    @(posedge clk); #1;

    // Reset state.
    cycle(1, 2'b00, 2'b00, '0, '0, '0, '0, '0);
    cycle(1, 2'b00, 2'b00, '0, '0, '0, '0, '0);
    chk("reset_gid", 64'(grant_id), 64'd0);
    cycle(0, 2'b00, 2'b00, '0, '0, '0, '0, '0);

    // Single cpu write.
    cycle(0, 2'b01, 2'b01, 32'h40, '0, 32'hDEADBEEF, '0, '0);
    chk("wr_ready", 64'(s_ready), 64'b01);
    chk("wr_en_we", 64'({s_en, s_we}), 64'b11);
    chk("wr_addr", 64'(s_addr), 64'h40);
    cycle(0, 2'b00, 2'b00, '0, '0, '0, '0, '0);
    chk("wr_no_rsp", 64'(s_rsp), 64'd0);

    // cpu read, then a cpu write held off until the read completes.
    cycle(0, 2'b01, 2'b00, 32'h80, '0, '0, '0, 32'h12345678);
    chk("rd_accept", 64'(s_ready), 64'b01);
    for (int k = 1; k <= int'(RDL) + 1; k++) begin
      cycle(0, 2'b01, 2'b01, 32'h84, '0, 32'hA5A5, '0, 32'h12345678);
      if (k == int'(RDL)) begin
        chk("rd_rsp", 64'(s_rsp), 64'b01);
        chk("rd_data", 64'(s_rdata), 64'h12345678);
      end
      chk("rd_hold_ready", 64'(s_ready), (k == int'(RDL) + 1) ? 64'b01 : 64'b00);
    end

    // Both requesters writing continuously from reset.
    cycle(1, 2'b00, 2'b00, '0, '0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 2'b11, 2'b11, 32'h100 + 32'(k), 32'h200 + 32'(k), 32'(k), 32'(k), '0);
`ifdef MEM_ARB_CPU_PRIORITY_EN
      chk("alt_ready", 64'(s_ready), 64'b01);
      chk("alt_gid", 64'(grant_id), 64'd0);
`else
      chk("alt_ready", 64'(s_ready), (k % 2 == 1) ? 64'b10 : 64'b01);
      chk("alt_gid", 64'(grant_id), 64'(k % 2));
`endif
    end
    cycle(0, 2'b10, 2'b10, '0, 32'h300, '0, 32'h33, '0);
    chk("dma_alone", 64'(s_ready), 64'b10);

    // dma read pending while cpu asks to write.
    cycle(0, 2'b10, 2'b00, '0, 32'h400, '0, '0, 32'hCAFE0001);
    chk("dma_rd_accept", 64'(s_ready), 64'b10);
    for (int k = 1; k <= int'(RDL) + 1; k++) begin
      cycle(0, 2'b01, 2'b01, 32'h44, '0, 32'h77, '0, 32'hCAFE0001);
      if (k == int'(RDL)) chk("dma_rsp", 64'(s_rsp), 64'b10);
      chk("cpu_held", 64'(s_ready), (k == int'(RDL) + 1) ? 64'b01 : 64'b00);
    end

    // Reset in the cycle after a read is accepted.
    cycle(0, 2'b10, 2'b00, '0, 32'h500, '0, '0, 32'h5555);
    cycle(1, 2'b00, 2'b00, '0, '0, '0, '0, 32'h5555);
    for (int k = 0; k < int'(RDL); k++) begin
      cycle(0, 2'b00, 2'b00, '0, '0, '0, '0, 32'h5555);
      chk("rst_no_rsp", 64'(s_rsp), 64'd0);
    end
    chk("rst_gid", 64'(grant_id), 64'd0);

    // Random traffic; requesters hold each request until accepted.
    pv = '0; pwe = '0;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 199) == 0);
      if (rr) pv = '0;
      else begin
        for (int i = 0; i < 2; i++) begin
          if (!pv[i] && $urandom_range(0, 2) != 0) begin
            pv[i]  = 1'b1;
            pwe[i] = 1'($urandom_range(0, 1));
            pa[i]  = $urandom;
            pd[i]  = $urandom;
          end
        end
      end
      cycle(rr, pv, pwe, pa[0], pa[1], pd[0], pd[1], $urandom);
      if (m_last_g >= 0) pv[m_last_g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
